sqrt_seq_param: RTL and testbench
=================================

Name: sqrt_seq_param

Overview:
Parametrised sequential unsigned integer square root: one result bit resolved per clock using a trial-bit / square-compare loop. Successor to the fixed 32-bit start/stop square-root unit.
- Adds generic operand width.
- Adds a busy/done handshake in place of the external stop strobe.
- Adds remainder output, optional round-to-nearest with saturation flag, and abort.
- Sits as a multi-cycle arithmetic slave behind a controller that issues start and waits for done.

Parameters:
NBITSIN, 32, operand width; must be even, 4 <= NBITSIN <= 62 (elaboration error otherwise).
NBITSOUT, NBITSIN/2, result width (derived; not to be overridden).

Ports:
clock  input  1  master clock, rising edge
reset  input  1  synchronous reset, active-high
start  input  1  begin new operation; sampled only in IDLE
abort  input  1  cancel operation in progress; no done issued
round  input  1  0 = truncate (floor), 1 = round to nearest; sampled with start
xin  input  NBITSIN  operand, unsigned
busy  output  1  high while an operation is in progress (state != IDLE)
done  output  1  one-cycle pulse when sqrt/rem/sat update
sqrt  output  NBITSOUT  result, unsigned
rem  output  NBITSOUT+1  xin - floor(sqrt(xin))^2, always the truncated remainder
sat  output  1  round-up requested but floor result was all ones; sqrt held at max

Behaviour:
- All arithmetic is unsigned. The trial square is a full 2*NBITSOUT-bit product; no signed types anywhere.
- Reset: state IDLE, busy=0, done=0, sqrt=0, rem=0, sat=0; internal operand, partial result and trial bit cleared. Reset overrides start and abort in the same cycle. Reset mid-operation discards the operation.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 at an edge (E0) latches xin and round, clears the partial result, sets trial bit = 1<<(NBITSOUT-1), and moves to CALC.
  - start=0: remain in IDLE.
- CALC:
  - Each edge: test = partial | bit. If x >= test*test, partial <= test. Then bit <= bit>>1.
  - After NBITSOUT such edges (E1..E_N, N = NBITSOUT), move to FIN.
- FIN (edge E_N+1):
  - rem <= x - partial^2.
  - If round=1 and rem > partial: round up to partial+1, unless partial is all ones; in that case sqrt <= all ones and sat <= 1.
  - Otherwise sqrt <= partial and sat <= 0.
  - done <= 1 for exactly one cycle; move to IDLE.
- Latency: done is high during the cycle after edge E_(N+1), i.e. N+2 clocks after the start edge. busy is high from after E0 until done rises; busy=0 while done=1.
- Back-to-back: start asserted in the done cycle is accepted, because the state is already IDLE.
- start while busy: ignored; xin and round are not resampled.
- abort:
  - In CALC or FIN: return to IDLE at the next edge; no done; sqrt/rem/sat keep their previous values.
  - In IDLE: no effect.
  - abort and start in the same IDLE cycle: start wins, abort ignored.
- sqrt/rem/sat change only on done-producing edges or reset; they hold indefinitely otherwise.
- Boundaries:
  - xin=0 gives 0/0.
  - xin=all ones gives sqrt all ones, rem = 2*(2^N-1).
  - Perfect squares give rem=0 and are never rounded.

Test Plan:
- Reset, then NBITSIN=32, xin=1000000, round=0, start pulse -> done exactly 18 cycles after the start edge; sqrt=1000, rem=0, sat=0; busy high for 17 cycles.
- xin=0xFFFFFFFF, round=0 -> sqrt=0xFFFF, rem=0x1FFFE, sat=0. Same operand with round=1 -> sqrt=0xFFFF, sat=1.
- round=1 boundaries: xin=2 -> sqrt=1, rem=1 (1 not > 1, no round). xin=3 -> sqrt=2, rem=2. xin=12 -> sqrt=3, rem=3 (round down). xin=13 -> sqrt=4, rem=4.
- start held high for 5 cycles with xin changing every cycle -> only the first xin is used; done occurs once. Next start asserted in the done cycle -> second result exactly 18 cycles later.
- abort asserted 5 cycles after start -> no done, busy falls the next cycle, outputs retain the prior result. Reset asserted mid-CALC -> all outputs 0, next start works.
- NBITSIN=8 instance: xin=200 -> sqrt=14, rem=4, done 6 cycles after start. Sweep 0..255 against a floor-sqrt reference model for both round modes.

Source files
------------

// File: rtl/sqrt_seq_param.sv
// sqrt_seq_param: sequential unsigned integer square root.
// Resolves one result bit per clock by trial-bit / square-compare. The
// truncated remainder is always reported. Optional round-to-nearest
// saturates at the all-ones result. Uses a start / busy / done handshake
// and can be cancelled with abort.
module sqrt_seq_param #(
    parameter int NBITSIN  = 32,
    parameter int NBITSOUT = NBITSIN / 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                round,
    input  logic [NBITSIN-1:0]  xin,
    output logic                busy,
    output logic                done,
    output logic [NBITSOUT-1:0] sqrt,
    output logic [NBITSOUT:0]   rem,
    output logic                sat
);

    // Reject unsupported operand widths at elaboration time.
    generate
        if ((NBITSIN % 2) != 0 || NBITSIN < 4 || NBITSIN > 62) begin : g_bad_nbitsin
            $error("sqrt_seq_param: NBITSIN must be even and within 4..62");
        end
        if (NBITSOUT != NBITSIN / 2) begin : g_bad_nbitsout
            $error("sqrt_seq_param: NBITSOUT is derived and must equal NBITSIN/2");
        end
    endgenerate

    // The squares of NBITSOUT-bit values fill exactly the operand width.
    localparam int SQ_W = 2 * NBITSOUT;

    // Trial bit that is loaded at start: the MSB of the result.
    localparam logic [NBITSOUT-1:0] TOP_BIT = {1'b1, {(NBITSOUT-1){1'b0}}};
    localparam logic [NBITSOUT-1:0] ONE_OUT = {{(NBITSOUT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Full-width unsigned square of a result-sized value.
    function automatic logic [SQ_W-1:0] square(input logic [NBITSOUT-1:0] v);
        logic [SQ_W-1:0] ve;
        ve = {{NBITSOUT{1'b0}}, v};
        return ve * ve;
    endfunction

    // Final result selection. Returns {sat, sqrt}. The result is rounded up
    // only when the remainder strictly exceeds the floor root. A floor root
    // that is already all ones cannot be incremented, so it is held and
    // flagged as saturated.
    function automatic logic [NBITSOUT:0] round_result(
        input logic [NBITSOUT-1:0] p,
        input logic [NBITSIN-1:0]  r,
        input logic                rnd
    );
        logic up;
        up = rnd && (r > {{(NBITSIN-NBITSOUT){1'b0}}, p});
        if (up && (&p)) begin
            return {1'b1, p};
        end else if (up) begin
            return {1'b0, p + ONE_OUT};
        end else begin
            return {1'b0, p};
        end
    endfunction

    state_t                state_q, state_d;
    logic [NBITSIN-1:0]    x_q, x_d;
    logic                  round_q, round_d;
    logic [NBITSOUT-1:0]   part_q, part_d;
    logic [NBITSOUT-1:0]   bit_q, bit_d;
    logic [NBITSOUT-1:0]   sqrt_q, sqrt_d;
    logic [NBITSOUT:0]     rem_q, rem_d;
    logic                  sat_q, sat_d;
    logic                  done_q, done_d;

    logic [NBITSOUT-1:0]   trial;
    logic [SQ_W-1:0]       trial_sq;
    logic [NBITSIN-1:0]    rem_full;
    logic [NBITSOUT:0]     fin_res;

    // Datapath helpers: the candidate for this step and the floor remainder.
    always_comb begin
        trial    = part_q | bit_q;
        trial_sq = square(trial);
        rem_full = x_q - square(part_q);
        fin_res  = round_result(part_q, rem_full, round_q);
    end

    // Next-state and next-value logic for the control FSM and the datapath.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        round_d = round_q;
        part_d  = part_q;
        bit_d   = bit_q;
        sqrt_d  = sqrt_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // When start is high, the operation launches even if abort is also high.
                if (start) begin
                    x_d     = xin;
                    round_d = round;
                    part_d  = '0;
                    bit_d   = TOP_BIT;
                    state_d = CALC;
                end
            end

            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (x_q >= trial_sq) begin
                        part_d = trial;
                    end
                    bit_d = bit_q >> 1;
                    // The trial bit sitting in the LSB marks the last step.
                    if (bit_q[0]) begin
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rem_d            = rem_full[NBITSOUT:0];
                    {sat_d, sqrt_d}  = fin_res;
                    done_d           = 1'b1;
                    state_d          = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            round_q <= 1'b0;
            part_q  <= '0;
            bit_q   <= '0;
            sqrt_q  <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            round_q <= round_d;
            part_q  <= part_d;
            bit_q   <= bit_d;
            sqrt_q  <= sqrt_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sqrt = sqrt_q;
    assign rem  = rem_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_sqrt_seq_param.sv
// Testbench for sqrt_seq_param: a 32-bit and an 8-bit instance, with
// scoreboard queues filled by the driver and drained by done monitors.
module tb_sqrt_seq_param;

    typedef struct {
        longint unsigned sq;
        longint unsigned rm;
        bit              st;
        int              cyc;
    } exp_t;

    logic        clock;
    logic        reset;

    logic        start32, abort32, round32;
    logic [31:0] xin32;
    logic        busy32, done32, sat32;
    logic [15:0] sqrt32;
    logic [16:0] rem32;

    logic        start8, abort8, round8;
    logic [7:0]  xin8;
    logic        busy8, done8, sat8;
    logic [3:0]  sqrt8;
    logic [4:0]  rem8;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t q32[$];
    exp_t q8[$];
    exp_t m32_e;
    exp_t m8_e;

    sqrt_seq_param #(.NBITSIN(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .abort(abort32),
        .round(round32), .xin(xin32), .busy(busy32), .done(done32),
        .sqrt(sqrt32), .rem(rem32), .sat(sat32)
    );

    sqrt_seq_param #(.NBITSIN(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8),
        .round(round8), .xin(xin8), .busy(busy8), .done(done8),
        .sqrt(sqrt8), .rem(rem8), .sat(sat8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Floor square root by linear search, then optional rounding.
    task automatic ref_sqrt(input int x, input int nout, input bit r,
                            output longint unsigned s, output longint unsigned rm, output bit st);
        longint unsigned f;
        longint unsigned maxv;
        f = 0;
        while ((f + 1) * (f + 1) <= longint'(x)) f++;
        rm   = longint'(x) - f * f;
        maxv = (64'd1 << nout) - 1;
        s    = f;
        st   = 1'b0;
        if (r && rm > f) begin
            if (f == maxv) st = 1'b1;
            else s = f + 1;
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clock) begin
        if (!reset && done32) begin
            if (q32.size() == 0) begin
                check("dut32_unexpected_done", 1, 0);
            end else begin
                m32_e = q32.pop_front();
                check("dut32_sqrt", sqrt32, m32_e.sq);
                check("dut32_rem", rem32, m32_e.rm);
                check("dut32_sat", sat32, m32_e.st);
                check("dut32_done_cycle", cyc, m32_e.cyc);
                check("dut32_busy_in_done", busy32, 0);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clock) begin
        if (!reset && done8) begin
            if (q8.size() == 0) begin
                check("dut8_unexpected_done", 1, 0);
            end else begin
                m8_e = q8.pop_front();
                check("dut8_sqrt", sqrt8, m8_e.sq);
                check("dut8_rem", rem8, m8_e.rm);
                check("dut8_sat", sat8, m8_e.st);
                check("dut8_done_cycle", cyc, m8_e.cyc);
            end
        end
    end

    // Called at a negedge; drives a one-cycle start and returns one negedge later.
    task automatic op32(input logic [31:0] x, input logic r, input longint unsigned es,
                        input longint unsigned er, input bit esat, input bit expect_done);
        exp_t e;
        if (expect_done) begin
            e.sq = es; e.rm = er; e.st = esat; e.cyc = cyc + 18;
            q32.push_back(e);
        end
        xin32 = x; round32 = r; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
    endtask

    task automatic run32(input logic [31:0] x, input logic r, input longint unsigned es,
                         input longint unsigned er, input bit esat);
        op32(x, r, es, er, esat, 1'b1);
        repeat (18) @(negedge clock);
    endtask

    task automatic op8(input logic [7:0] x, input logic r, input longint unsigned es,
                       input longint unsigned er, input bit esat);
        exp_t e;
        e.sq = es; e.rm = er; e.st = esat; e.cyc = cyc + 6;
        q8.push_back(e);
        xin8 = x; round8 = r; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
    endtask

    initial begin
        int nb;
        longint unsigned s, rm;
        bit st;

        reset = 1'b1;
        start32 = 1'b0; abort32 = 1'b0; round32 = 1'b0; xin32 = '0;
        start8  = 1'b0; abort8  = 1'b0; round8  = 1'b0; xin8  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("reset_busy", busy32, 0);
        check("reset_done", done32, 0);
        check("reset_sqrt", sqrt32, 0);
        check("reset_rem", rem32, 0);
        check("reset_sat", sat32, 0);
        check("reset_busy8", busy8, 0);

        // First operation: latency and busy window.
        op32(32'd1000000, 1'b0, 1000, 0, 1'b0, 1'b1);
        nb = 0;
        for (int i = 0; i < 17; i++) begin
            if (busy32) nb++;
            @(negedge clock);
        end
        check("busy_cycles", nb, 17);
        check("busy_low_in_done", busy32, 0);
        @(negedge clock);

        // Boundaries and rounding.
        run32(32'hFFFF_FFFF, 1'b0, 16'hFFFF, 17'h1FFFE, 1'b0);
        run32(32'hFFFF_FFFF, 1'b1, 16'hFFFF, 17'h1FFFE, 1'b1);
        run32(32'd2,  1'b1, 1, 1, 1'b0);
        run32(32'd3,  1'b1, 2, 2, 1'b0);
        run32(32'd12, 1'b1, 3, 3, 1'b0);
        run32(32'd13, 1'b1, 4, 4, 1'b0);
        run32(32'd0,  1'b0, 0, 0, 1'b0);
        run32(32'd0,  1'b1, 0, 0, 1'b0);
        run32(32'd1000000, 1'b1, 1000, 0, 1'b0);

        // Start held for 5 cycles with a changing operand, then back-to-back start.
        begin
            exp_t e;
            e.sq = 223; e.rm = 271; e.st = 1'b0; e.cyc = cyc + 18;
            q32.push_back(e);
        end
        xin32 = 32'd50000; round32 = 1'b0; start32 = 1'b1;
        repeat (4) begin
            @(negedge clock);
            xin32 = xin32 + 32'd7;
            round32 = 1'b1;
        end
        @(negedge clock);
        start32 = 1'b0;
        repeat (13) @(negedge clock);
        op32(32'd65536, 1'b0, 256, 0, 1'b0, 1'b1);
        repeat (18) @(negedge clock);

        // Abort mid-calculation: no done, outputs keep the last result.
        op32(32'd999, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        abort32 = 1'b1;
        check("busy_before_abort", busy32, 1);
        @(negedge clock);
        abort32 = 1'b0;
        check("busy_after_abort", busy32, 0);
        repeat (20) @(negedge clock);
        check("abort_keeps_sqrt", sqrt32, 256);
        check("abort_keeps_rem", rem32, 0);
        check("abort_keeps_sat", sat32, 0);

        // Abort in IDLE together with start: start wins.
        abort32 = 1'b1;
        op32(32'd144, 1'b0, 12, 0, 1'b0, 1'b1);
        abort32 = 1'b0;
        repeat (18) @(negedge clock);

        // Reset mid-calculation clears everything; next start still works.
        op32(32'd12345, 1'b1, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_busy", busy32, 0);
        check("midreset_done", done32, 0);
        check("midreset_sqrt", sqrt32, 0);
        check("midreset_rem", rem32, 0);
        check("midreset_sat", sat32, 0);
        repeat (20) @(negedge clock);
        run32(32'd1000000, 1'b0, 1000, 0, 1'b0);

        // 8-bit instance: directed value then full sweep, back-to-back.
        op8(8'd200, 1'b0, 14, 4, 1'b0);
        repeat (6) @(negedge clock);
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 256; x++) begin
                ref_sqrt(x, 4, r[0], s, rm, st);
                op8(x[7:0], r[0], s, rm, st);
                repeat (5) @(negedge clock);
            end
        end
        repeat (8) @(negedge clock);

        check("q32_drained", q32.size(), 0);
        check("q8_drained", q8.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
